// File: rtl/cache_ctrl.sv
// Direct-mapped write-through cache controller: 128 one-word lines, owns tag/valid
// storage and sequences hits, refills and write-through in front of cache_decoder.
module cache_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int INDEX_W = 7,
    parameter int TAG_W   = ADDR_W - INDEX_W - 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [ADDR_W-1:0]  cpu_addr,
    input  logic [DATA_W-1:0]  cpu_wdata,
    output logic [DATA_W-1:0]  cpu_rdata,
    output logic               cpu_ready,
    input  logic               flush,
    output logic [INDEX_W-1:0] line_index,
    output logic               line_we,
    output logic [DATA_W-1:0]  line_wdata,
    input  logic [DATA_W-1:0]  line_rdata,
    output logic               mem_req,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata,
    input  logic               mem_ack
);
    // state  | meaning
    // IDLE   | wait for request; apply direct or pending flush
    // LOOKUP | tag compare on the latched address
    // REFILL | load miss, waiting for memory read data
    // WRMEM  | store write-through, waiting for memory ack
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        REFILL = 2'd2,
        WRMEM  = 2'd3
    } state_t;

    localparam int LINES = 1 << INDEX_W;

    state_t             state, state_nxt;
    logic [ADDR_W-3:0]  word_q;
    logic               we_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [LINES-1:0]   valid;
    logic [TAG_W-1:0]   tag_mem [LINES];
    logic               flush_pending;
    logic [INDEX_W-1:0] idx_q;
    logic [TAG_W-1:0]   tag_q;
    logic               hit;
    logic               flush_now;
    logic               accept;
    logic               unused_addr;

    assign idx_q       = word_q[INDEX_W-1:0];
    assign tag_q       = word_q[ADDR_W-3:INDEX_W];
    assign hit         = valid[idx_q] && (tag_mem[idx_q] == tag_q);
    assign flush_now   = flush || flush_pending;
    // cpu_ready high means the CPU is still holding the request it just completed
    assign accept      = (state == IDLE) && !flush_now && cpu_req && !cpu_ready;
    assign unused_addr = &{1'b0, cpu_addr[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = LOOKUP;
            LOOKUP:  state_nxt = we_q ? WRMEM : (hit ? IDLE : REFILL);
            REFILL:  if (mem_ack) state_nxt = IDLE;
            WRMEM:   if (mem_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        line_we    = 1'b0;
        line_wdata = '0;
        case (state)
            LOOKUP: begin
                if (we_q && hit) begin
                    line_we    = 1'b1;
                    line_wdata = wdata_q;
                end
            end
            REFILL: begin
                if (mem_ack) begin
                    line_we    = 1'b1;
                    line_wdata = mem_rdata;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q        <= '0;
            we_q          <= 1'b0;
            wdata_q       <= '0;
            valid         <= '0;
            flush_pending <= 1'b0;
            line_index    <= '0;
            cpu_ready     <= 1'b0;
            cpu_rdata     <= '0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
        end else begin
            cpu_ready <= 1'b0;
            if (state == IDLE) flush_pending <= 1'b0;
            else if (flush)    flush_pending <= 1'b1;
            case (state)
                IDLE: begin
                    if (flush_now) begin
                        valid <= '0;
                    end else if (accept) begin
                        word_q     <= cpu_addr[ADDR_W-1:2];
                        we_q       <= cpu_we;
                        wdata_q    <= cpu_wdata;
                        line_index <= cpu_addr[INDEX_W+1:2];
                    end
                end
                LOOKUP: begin
                    if (we_q) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {word_q, 2'b00};
                        mem_wdata <= wdata_q;
                    end else if (hit) begin
                        cpu_rdata <= line_rdata;
                        cpu_ready <= 1'b1;
                    end else begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= {word_q, 2'b00};
                    end
                end
                REFILL: begin
                    if (mem_ack) begin
                        valid[idx_q] <= 1'b1;
                        cpu_rdata    <= mem_rdata;
                        cpu_ready    <= 1'b1;
                        mem_req      <= 1'b0;
                    end
                end
                WRMEM: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        cpu_ready <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tags need no reset: a line is only trusted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (state == REFILL && mem_ack) tag_mem[idx_q] <= tag_q;
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Randomized bench for cache_ctrl: a word-level memory/cache model predicts hits,
// load data, line writes and memory traffic; directed steps pin the model first.
module tb_cache_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, flush = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic [6:0]  line_index;
    logic        line_we;
    logic [31:0] line_wdata, line_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    always #5 clk = ~clk;

    cache_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .flush(flush),
        .line_index(line_index), .line_we(line_we), .line_wdata(line_wdata),
        .line_rdata(line_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    // line data array that cache_decoder would enable
    logic [31:0] line_arr [128];
    always @(posedge clk) if (line_we) line_arr[line_index] <= line_wdata;
    assign line_rdata = line_arr[line_index];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [29:0] w);
        return ({2'b00, w} * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
    endfunction

    // reference model: memory contents and which line holds which tag
    logic [31:0] ref_mem [logic [29:0]];
    logic [31:0] env_mem [logic [29:0]];
    bit          mv [128];
    logic [22:0] mt [128];

    function automatic logic [31:0] ref_rd(input logic [29:0] w);
        return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
    endfunction
    function automatic logic [31:0] env_rd(input logic [29:0] w);
        return env_mem.exists(w) ? env_mem[w] : init_word(w);
    endfunction

    logic        txn_active = 1'b0, quiet = 1'b0, done = 1'b0;
    logic        hold_mem = 1'b0, spur_en = 1'b0;
    logic        cur_we = 1'b0, cur_hit = 1'b0, chk_lat = 1'b0;
    logic [31:0] cur_addr = '0, cur_wd = '0, cur_exp = '0;
    int          cyc = 0, nlwe = 0, nmreq = 0;
    logic        prev_ack = 1'b0;
    logic [31:0] last_rdata = '0, last_mem_addr = '0, last_line_wdata = '0;
    logic [6:0]  last_line_idx = '0;
    logic        last_mem_we = 1'b0;

    // single compare process against the model's expectations for the current access
    always @(negedge clk) begin
        if (rst_n && !quiet) begin
            if (!txn_active) begin
                if (line_we || mem_req || cpu_ready)
                    chk("stray_activity", {29'd0, line_we, mem_req, cpu_ready}, 32'd0);
            end else begin
                cyc++;
                if (line_we) begin
                    nlwe++;
                    last_line_wdata = line_wdata;
                    chk("line_index", 32'(line_index), 32'(cur_addr[8:2]));
                    chk("line_wdata", line_wdata, cur_we ? cur_wd : cur_exp);
                end
                if (mem_req) begin
                    nmreq++;
                    last_mem_addr = mem_addr;
                    last_mem_we   = mem_we;
                    chk("mem_addr", mem_addr, {cur_addr[31:2], 2'b00});
                    chk("mem_we", 32'(mem_we), 32'(cur_we));
                    if (cur_we) chk("mem_wdata", mem_wdata, cur_wd);
                end
                if (cpu_ready) begin
                    chk("ready_once", 32'(done), 32'd0);
                    done = 1'b1;
                    last_rdata    = cpu_rdata;
                    last_line_idx = line_index;
                    if (!cur_we) chk("cpu_rdata", cpu_rdata, cur_exp);
                    chk("line_we_count", 32'(nlwe), (cur_we == cur_hit) ? 32'd1 : 32'd0);
                    chk("mem_used", 32'(nmreq != 0), 32'(!(!cur_we && cur_hit)));
                    if (!cur_we && cur_hit && chk_lat) chk("hit_latency", 32'(cyc), 32'd3);
                    if (!(!cur_we && cur_hit)) chk("ready_after_ack", 32'(prev_ack), 32'd1);
                end
            end
        end
        prev_ack = mem_ack && mem_req;
    end

    // memory: random ack delay, occasional acks with no request pending
    int wait_cnt = 0;
    initial begin
        forever begin
            @(posedge clk); #1;
            if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (hold_mem || !rst_n) begin
                mem_ack = 1'b0;
            end else if (mem_req) begin
                if (wait_cnt == 0) begin
                    mem_ack = 1'b1;
                    if (mem_we) env_mem[mem_addr[31:2]] = mem_wdata;
                    else        mem_rdata = env_rd(mem_addr[31:2]);
                    wait_cnt = $urandom_range(0, 3);
                end else begin
                    wait_cnt--;
                end
            end else if (spur_en && $urandom_range(0, 9) == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = $urandom;
            end
        end
    end

    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic fw, input logic fm);
        logic [6:0]  idx;
        logic [22:0] tg;
        logic [29:0] w;
        w   = addr[31:2];
        idx = addr[8:2];
        tg  = addr[31:9];
        if (fw) for (int i = 0; i < 128; i++) mv[i] = 1'b0;
        cur_we   = we;
        cur_addr = addr;
        cur_wd   = wd;
        cur_hit  = mv[idx] && (mt[idx] == tg);
        cur_exp  = ref_rd(w);
        chk_lat  = !fw;
        cyc = 0; nlwe = 0; nmreq = 0; done = 1'b0;
        txn_active = 1'b1;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr | 32'($urandom_range(0, 3));
        cpu_wdata = wd;
        flush     = fw;
        for (int i = 0; i < 80 && !done; i++) begin
            @(negedge clk); #1;
            if (fw && i == 1) flush = 1'b0;
            if (fm && i == 2) flush = 1'b1;
            if (fm && i == 3) flush = 1'b0;
        end
        if (!done) chk("ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        flush      = 1'b0;
        cpu_req    = 1'b0;
        txn_active = 1'b0;
        if (!we && !cur_hit) begin
            mv[idx] = 1'b1;
            mt[idx] = tg;
        end
        if (we) ref_mem[w] = wd;
        if (fm) for (int i = 0; i < 128; i++) mv[i] = 1'b0;
    endtask

    task automatic reset_mid();
        logic seen;
        seen     = 1'b0;
        hold_mem = 1'b1;
        quiet    = 1'b1;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h10;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = mem_req;
        end
        chk("rst_mid_in_refill", 32'(seen), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mid_mem_addr", mem_addr, 32'd0);
        chk("rst_mid_cpu_ready", 32'(cpu_ready), 32'd0);
        chk("rst_mid_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_mid_line_index", 32'(line_index), 32'd0);
        chk("rst_mid_line_we", 32'(line_we), 32'd0);
        cpu_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 128; i++) mv[i] = 1'b0;
        hold_mem = 1'b0;
        quiet    = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        logic [6:0]  ri;
        logic [22:0] rt;
        for (int i = 0; i < 128; i++) begin
            line_arr[i] = '0;
            mv[i] = 1'b0;
            mt[i] = '0;
        end
        repeat (2) @(negedge clk);
        chk("rst_cpu_ready", 32'(cpu_ready), 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_line_index", 32'(line_index), 32'd0);
        chk("rst_line_we", 32'(line_we), 32'd0);
        chk("rst_line_wdata", line_wdata, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        ref_mem[30'h4] = 32'hDEAD_BEEF;
        env_mem[30'h4] = 32'hDEAD_BEEF;
        access(1'b0, 32'h10, 32'h0, 1'b0, 1'b0);
        chk("d1_miss", 32'(nmreq != 0), 32'd1);
        chk("d1_mem_addr", last_mem_addr, 32'h10);
        chk("d1_line_index", 32'(last_line_idx), 32'd4);
        chk("d1_rdata", last_rdata, 32'hDEAD_BEEF);
        chk("d1_line_we", 32'(nlwe), 32'd1);

        access(1'b0, 32'h10, 32'h0, 1'b0, 1'b0);
        chk("d2_no_mem", 32'(nmreq), 32'd0);
        chk("d2_latency", 32'(cyc), 32'd3);
        chk("d2_rdata", last_rdata, 32'hDEAD_BEEF);

        access(1'b0, 32'h210, 32'h0, 1'b0, 1'b0);
        chk("d3_conflict_miss", 32'(nmreq != 0), 32'd1);
        access(1'b0, 32'h10, 32'h0, 1'b0, 1'b0);
        chk("d3_evicted_miss", 32'(nmreq != 0), 32'd1);
        chk("d3_rdata", last_rdata, 32'hDEAD_BEEF);

        access(1'b1, 32'h10, 32'h1234_5678, 1'b0, 1'b0);
        chk("d4_store_hit_lwe", 32'(nlwe), 32'd1);
        chk("d4_store_wdata", last_line_wdata, 32'h1234_5678);
        chk("d4_store_mem_we", 32'(last_mem_we), 32'd1);
        access(1'b0, 32'h10, 32'h0, 1'b0, 1'b0);
        chk("d4_hit_after_store", 32'(nmreq), 32'd0);
        chk("d4_rdata", last_rdata, 32'h1234_5678);

        access(1'b1, 32'h1FC, 32'hCAFE_F00D, 1'b0, 1'b0);
        chk("d5_store_miss_lwe", 32'(nlwe), 32'd0);
        chk("d5_store_miss_addr", last_mem_addr, 32'h1FC);
        access(1'b0, 32'h1FC, 32'h0, 1'b0, 1'b0);
        chk("d5_rdata", last_rdata, 32'hCAFE_F00D);

        access(1'b0, 32'h10, 32'h0, 1'b1, 1'b0);
        chk("d6_flush_with_req", 32'(nmreq != 0), 32'd1);
        access(1'b0, 32'h210, 32'h0, 1'b0, 1'b1);
        access(1'b0, 32'h210, 32'h0, 1'b0, 1'b0);
        chk("d6_flush_pending", 32'(nmreq != 0), 32'd1);
        access(1'b0, 32'h210, 32'h0, 1'b0, 1'b1);
        access(1'b0, 32'h210, 32'h0, 1'b0, 1'b0);
        chk("d6_flush_pending2", 32'(nmreq != 0), 32'd1);
        access(1'b0, 32'h10, 32'h0, 1'b0, 1'b1);

        reset_mid();
        access(1'b0, 32'h10, 32'h0, 1'b0, 1'b0);
        chk("d7_miss_after_rst", 32'(nmreq != 0), 32'd1);
        chk("d7_rdata", last_rdata, 32'h1234_5678);

        access(1'b0, 32'h1FC, 32'h0, 1'b0, 1'b0);
        access(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        access(1'b0, 32'h1FC, 32'h0, 1'b0, 1'b0);
        chk("d8_wrap_hit", 32'(nmreq), 32'd0);

        spur_en = 1'b1;
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 4))
                0: ri = 7'h00;
                1: ri = 7'h04;
                2: ri = 7'h7F;
                3: ri = 7'h40;
                default: ri = 7'($urandom_range(0, 127));
            endcase
            case ($urandom_range(0, 2))
                0: rt = 23'h0;
                1: rt = 23'h1;
                default: rt = 23'h7F_FFFF;
            endcase
            a = {rt, ri, 2'b00};
            access($urandom_range(0, 9) < 3, a, $urandom,
                   $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0);
        end
        spur_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
